// File: rtl/control_unit.sv
// control_unit: multi-cycle instruction sequencer for a small RV64-subset datapath.
// The cu_instr handshake latches one word. The FSM then walks it through
// DECODE/EXECUTE/MEMORY/WRITEBACK and produces the datapath selects and write strobes.
// Optional feature: define CU_PERF_COUNT_EN to build the retired-instruction counter.
// Without that macro, cu_retired_count is tied to 0.
//
// state     | meaning
// IDLE      | ready for a new word, nothing in flight
// DECODE    | latched word decoded; illegal words are flagged here
// EXECUTE   | ALU cycle; BEQ resolves its branch here
// MEMORY    | data-memory cycle for LD/SD; SD write strobe
// WRITEBACK | register-file write strobe (suppressed for rd == x0)
module control_unit (
  input  logic        cu_clk,
  input  logic        cu_rst,
  input  logic [31:0] cu_instr,
  input  logic        cu_instr_valid,
  output logic        cu_instr_ready,
  input  logic        cu_alu_zero,
  output logic [4:0]  cu_rf_addr_a,
  output logic [4:0]  cu_rf_addr_b,
  output logic [4:0]  cu_rf_write_addr,
  output logic        cu_rf_write_en,
  output logic        cu_dm_write_en,
  output logic [63:0] cu_immediate,
  output logic        cu_mux_0_sel,
  output logic        cu_mux_1_sel,
  output logic        cu_mux_2_sel,
  output logic [2:0]  cu_alu_operation,
  output logic        cu_branch_taken,
  output logic        cu_illegal,
  output logic        cu_busy,
  output logic [31:0] cu_retired_count
);

  typedef enum logic [2:0] {IDLE, DECODE, EXECUTE, MEMORY, WRITEBACK} state_t;
  typedef enum logic [2:0] {C_ILL, C_LD, C_SD, C_ADDI, C_R, C_BEQ} cls_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  state_t      state, state_nxt;
  cls_t        cls;
  logic [31:0] instr_q;
  logic        accept;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];
  assign accept = cu_instr_valid && (state == IDLE);

  // Every operand the datapath sees is PC-free, so the first ALU input is always rf_a.
  assign cu_mux_0_sel = 1'b0;
  assign cu_busy      = (state != IDLE);

  // State register and instruction latch; a reset discards any word in flight.
  always_ff @(posedge cu_clk) begin
    if (cu_rst) begin
      state   <= IDLE;
      instr_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) instr_q <= cu_instr;
    end
  end

  // Decode the latched word. These outputs hold until the next accept because instr_q holds.
  // Illegal words, including the post-reset zero word, decode to all-zero fields.
  always_comb begin
    cls              = C_ILL;
    cu_rf_addr_a     = '0;
    cu_rf_addr_b     = '0;
    cu_rf_write_addr = '0;
    cu_immediate     = '0;
    cu_mux_1_sel     = 1'b0;
    cu_mux_2_sel     = 1'b0;
    cu_alu_operation = ALU_ADD;
    case (opcode)
      7'b0000011: if (funct3 == 3'b011) begin
        cls              = C_LD;
        cu_rf_addr_a     = instr_q[19:15];
        cu_rf_write_addr = instr_q[11:7];
        cu_immediate     = {{52{instr_q[31]}}, instr_q[31:20]};
      end
      7'b0100011: if (funct3 == 3'b011) begin
        cls          = C_SD;
        cu_rf_addr_a = instr_q[19:15];
        cu_rf_addr_b = instr_q[24:20];
        cu_immediate = {{52{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      end
      7'b0010011: if (funct3 == 3'b000) begin
        cls              = C_ADDI;
        cu_rf_addr_a     = instr_q[19:15];
        cu_rf_write_addr = instr_q[11:7];
        cu_immediate     = {{52{instr_q[31]}}, instr_q[31:20]};
        cu_mux_2_sel     = 1'b1;
      end
      7'b0110011: begin
        if (funct7 == 7'b0000000 && funct3 == 3'b000) begin
          cls = C_R; cu_alu_operation = ALU_ADD;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          cls = C_R; cu_alu_operation = ALU_SUB;
        end else if (funct7 == 7'b0000000 && funct3 == 3'b111) begin
          cls = C_R; cu_alu_operation = ALU_AND;
        end else if (funct7 == 7'b0000000 && funct3 == 3'b110) begin
          cls = C_R; cu_alu_operation = ALU_OR;
        end
        if (cls == C_R) begin
          cu_rf_addr_a     = instr_q[19:15];
          cu_rf_addr_b     = instr_q[24:20];
          cu_rf_write_addr = instr_q[11:7];
          cu_mux_1_sel     = 1'b1;
          cu_mux_2_sel     = 1'b1;
        end
      end
      7'b1100011: if (funct3 == 3'b000) begin
        cls              = C_BEQ;
        cu_rf_addr_a     = instr_q[19:15];
        cu_rf_addr_b     = instr_q[24:20];
        cu_immediate     = {{51{instr_q[31]}}, instr_q[31], instr_q[7],
                            instr_q[30:25], instr_q[11:8], 1'b0};
        cu_mux_1_sel     = 1'b1;
        cu_alu_operation = ALU_SUB;
      end
      default: cls = C_ILL;
    endcase
  end

  // Next-state and strobe logic. Reset masks every pulse in the cycle it is asserted.
  always_comb begin
    state_nxt       = state;
    cu_instr_ready  = 1'b0;
    cu_rf_write_en  = 1'b0;
    cu_dm_write_en  = 1'b0;
    cu_branch_taken = 1'b0;
    cu_illegal      = 1'b0;
    case (state)
      IDLE: begin
        cu_instr_ready = 1'b1;
        if (cu_instr_valid) state_nxt = DECODE;
      end
      DECODE: begin
        if (cls == C_ILL) begin
          cu_illegal = 1'b1;
          state_nxt  = IDLE;
        end else begin
          state_nxt = EXECUTE;
        end
      end
      EXECUTE: begin
        case (cls)
          C_LD, C_SD: state_nxt = MEMORY;
          C_BEQ: begin
            cu_branch_taken = cu_alu_zero;
            state_nxt       = IDLE;
          end
          default: state_nxt = WRITEBACK;
        endcase
      end
      MEMORY: begin
        if (cls == C_SD) begin
          cu_dm_write_en = 1'b1;
          state_nxt      = IDLE;
        end else begin
          state_nxt = WRITEBACK;
        end
      end
      WRITEBACK: begin
        cu_rf_write_en = (cu_rf_write_addr != 5'd0);
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (cu_rst) begin
      cu_rf_write_en  = 1'b0;
      cu_dm_write_en  = 1'b0;
      cu_branch_taken = 1'b0;
      cu_illegal      = 1'b0;
    end
  end

`ifdef CU_PERF_COUNT_EN
  logic        retire;
  logic [31:0] retired_q;

  assign retire = !cu_rst && ((state == WRITEBACK) ||
                              (state == MEMORY && cls == C_SD) ||
                              (state == EXECUTE && cls == C_BEQ));

  // Count completed legal instructions; wraps naturally at 32 bits.
  always_ff @(posedge cu_clk) begin
    if (cu_rst)      retired_q <= '0;
    else if (retire) retired_q <= retired_q + 32'd1;
  end

  assign cu_retired_count = retired_q;
`else
  assign cu_retired_count = '0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector bench for control_unit.
// It keeps a reference model built from per-class latency and decode rules and checks it every cycle.
module tb_control_unit;

  logic        cu_clk = 1'b0;
  logic        cu_rst;
  logic [31:0] cu_instr;
  logic        cu_instr_valid;
  logic        cu_instr_ready;
  logic        cu_alu_zero;
  logic [4:0]  cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr;
  logic        cu_rf_write_en, cu_dm_write_en;
  logic [63:0] cu_immediate;
  logic        cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel;
  logic [2:0]  cu_alu_operation;
  logic        cu_branch_taken, cu_illegal, cu_busy;
  logic [31:0] cu_retired_count;

  control_unit dut (
    .cu_clk(cu_clk), .cu_rst(cu_rst), .cu_instr(cu_instr), .cu_instr_valid(cu_instr_valid),
    .cu_instr_ready(cu_instr_ready), .cu_alu_zero(cu_alu_zero),
    .cu_rf_addr_a(cu_rf_addr_a), .cu_rf_addr_b(cu_rf_addr_b), .cu_rf_write_addr(cu_rf_write_addr),
    .cu_rf_write_en(cu_rf_write_en), .cu_dm_write_en(cu_dm_write_en), .cu_immediate(cu_immediate),
    .cu_mux_0_sel(cu_mux_0_sel), .cu_mux_1_sel(cu_mux_1_sel), .cu_mux_2_sel(cu_mux_2_sel),
    .cu_alu_operation(cu_alu_operation), .cu_branch_taken(cu_branch_taken),
    .cu_illegal(cu_illegal), .cu_busy(cu_busy), .cu_retired_count(cu_retired_count)
  );

  always #5 cu_clk = ~cu_clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction classes: 0 illegal, 1 LD, 2 SD, 3 ADDI, 4 R-type, 5 BEQ.
  typedef struct packed {
    logic [2:0]  c;
    logic [4:0]  a, b, wa;
    logic [63:0] imm;
    logic        m1, m2;
    logic [2:0]  alu;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [11:0] i12;
    logic [12:0] b13;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    d = '0;
    if (op == 7'h03 && f3 == 3'd3) begin
      d.c = 3'd1; d.a = w[19:15]; d.wa = w[11:7];
      i12 = w[31:20]; d.imm = longint'($signed(i12));
    end else if (op == 7'h23 && f3 == 3'd3) begin
      d.c = 3'd2; d.a = w[19:15]; d.b = w[24:20];
      i12 = {w[31:25], w[11:7]}; d.imm = longint'($signed(i12));
    end else if (op == 7'h13 && f3 == 3'd0) begin
      d.c = 3'd3; d.a = w[19:15]; d.wa = w[11:7]; d.m2 = 1'b1;
      i12 = w[31:20]; d.imm = longint'($signed(i12));
    end else if (op == 7'h33 && ((f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6)) ||
                                 (f7 == 7'h20 && f3 == 3'd0))) begin
      d.c = 3'd4; d.a = w[19:15]; d.b = w[24:20]; d.wa = w[11:7]; d.m1 = 1'b1; d.m2 = 1'b1;
      d.alu = (f7 == 7'h20) ? 3'd1 : (f3 == 3'd7) ? 3'd2 : (f3 == 3'd6) ? 3'd3 : 3'd0;
    end else if (op == 7'h63 && f3 == 3'd0) begin
      d.c = 3'd5; d.a = w[19:15]; d.b = w[24:20]; d.m1 = 1'b1; d.alu = 3'd1;
      b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; d.imm = longint'($signed(b13));
    end
    return d;
  endfunction

  // Cycles from the accept edge back to IDLE, per class.
  function automatic int lat_of(input logic [2:0] c);
    case (c)
      3'd1:    return 4;
      3'd2:    return 3;
      3'd3:    return 3;
      3'd4:    return 3;
      3'd5:    return 2;
      default: return 1;
    endcase
  endfunction

  // Model: which word is in flight and how many edges have passed since accept.
  logic        m_busy;
  int          m_p;
  logic [31:0] m_word;
  logic [31:0] m_cnt;

  always @(posedge cu_clk) begin
    if (cu_rst) begin
      m_busy <= 1'b0; m_p <= 0; m_word <= '0; m_cnt <= '0;
    end else if (m_busy) begin
      if (m_p + 1 == lat_of(decode(m_word).c)) begin
        m_busy <= 1'b0;
        if (decode(m_word).c != 3'd0) m_cnt <= m_cnt + 32'd1;
      end
      m_p <= m_p + 1;
    end else if (cu_instr_valid) begin
      m_busy <= 1'b1; m_p <= 0; m_word <= cu_instr;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge cu_clk) begin
    dec_t d;
    int   l;
    logic live;
    logic [31:0] exp_cnt;
    if (chk_en) begin
      d = decode(m_word);
      l = lat_of(d.c);
      live = m_busy && !cu_rst;
`ifdef CU_PERF_COUNT_EN
      exp_cnt = m_cnt;
`else
      exp_cnt = '0;
`endif
      chk("ready", cu_instr_ready, !m_busy);
      chk("busy", cu_busy, m_busy);
      chk("illegal", cu_illegal, live && d.c == 3'd0 && m_p == 0);
      chk("rf_we", cu_rf_write_en,
          live && (d.c == 3'd1 || d.c == 3'd3 || d.c == 3'd4) && d.wa != 5'd0 && m_p == l - 1);
      chk("dm_we", cu_dm_write_en, live && d.c == 3'd2 && m_p == 2);
      chk("branch", cu_branch_taken, live && d.c == 3'd5 && m_p == 1 && cu_alu_zero);
      chk("addr_a", cu_rf_addr_a, d.a);
      chk("addr_b", cu_rf_addr_b, d.b);
      chk("wr_addr", cu_rf_write_addr, d.wa);
      chk("imm", cu_immediate, d.imm);
      chk("mux0", cu_mux_0_sel, 1'b0);
      chk("mux1", cu_mux_1_sel, d.m1);
      chk("mux2", cu_mux_2_sel, d.m2);
      chk("alu", cu_alu_operation, d.alu);
      chk("retired", cu_retired_count, exp_cnt);
    end
  end

  // Issue one word and observe it until ready returns (bounded).
  task automatic run(input logic [31:0] w, input logic z, output int lat, output int nrf,
                     output int ndm, output int nbr, output int nil, output int rfph);
    nrf = 0; ndm = 0; nbr = 0; nil = 0; rfph = -1; lat = 0;
    @(posedge cu_clk); #1;
    cu_instr = w; cu_instr_valid = 1'b1; cu_alu_zero = z;
    @(posedge cu_clk); #1;
    cu_instr_valid = 1'b0;
    while (!cu_instr_ready && lat < 20) begin
      @(negedge cu_clk);
      if (cu_rf_write_en) begin nrf++; rfph = lat; end
      if (cu_dm_write_en) ndm++;
      if (cu_branch_taken) nbr++;
      if (cu_illegal) nil++;
      @(posedge cu_clk); #1;
      lat++;
    end
  endtask

  int lat, nrf, ndm, nbr, nil, rfph;
  logic [31:0] cnt_before;

  initial begin
    cu_rst = 1'b1; cu_instr = '0; cu_instr_valid = 1'b0; cu_alu_zero = 1'b0;
    repeat (2) @(posedge cu_clk);
    #1 cu_rst = 1'b0;
    chk_en = 1'b1;
    @(negedge cu_clk);
    chk("rst_ready", cu_instr_ready, 1'b1);
    chk("rst_busy", cu_busy, 1'b0);
    chk("rst_imm", cu_immediate, 64'd0);
    chk("rst_count", cu_retired_count, 32'd0);

    // ld x2,5(x7)
    run(32'h0053B103, 1'b0, lat, nrf, ndm, nbr, nil, rfph);
    chk("ld_lat", lat, 4); chk("ld_rf_n", nrf, 1); chk("ld_rf_ph", rfph, 3); chk("ld_dm_n", ndm, 0);
    chk("ld_a", cu_rf_addr_a, 5'd7); chk("ld_wa", cu_rf_write_addr, 5'd2);
    chk("ld_imm", cu_immediate, 64'h5); chk("ld_alu", cu_alu_operation, 3'b000);
    chk("ld_mux", {cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel}, 3'b000);

    // add x3,x1,x2
    run(32'h002081B3, 1'b0, lat, nrf, ndm, nbr, nil, rfph);
    chk("add_lat", lat, 3); chk("add_rf_n", nrf, 1); chk("add_rf_ph", rfph, 2); chk("add_dm_n", ndm, 0);
    chk("add_a", cu_rf_addr_a, 5'd1); chk("add_b", cu_rf_addr_b, 5'd2);
    chk("add_mux", {cu_mux_1_sel, cu_mux_2_sel}, 2'b11); chk("add_alu", cu_alu_operation, 3'b000);

    // sd x5,-8(x6)
    run(32'hFE533C23, 1'b0, lat, nrf, ndm, nbr, nil, rfph);
    chk("sd_lat", lat, 3); chk("sd_dm_n", ndm, 1); chk("sd_rf_n", nrf, 0);
    chk("sd_imm", cu_immediate, 64'hFFFF_FFFF_FFFF_FFF8); chk("sd_b", cu_rf_addr_b, 5'd5);

    // beq x1,x2,+16, taken and not taken
    run(32'h00208863, 1'b1, lat, nrf, ndm, nbr, nil, rfph);
    chk("beq1_lat", lat, 2); chk("beq1_br", nbr, 1); chk("beq1_strobes", nrf + ndm, 0);
    chk("beq_imm", cu_immediate, 64'h10); chk("beq_alu", cu_alu_operation, 3'b001);
    chk("beq_mux1", cu_mux_1_sel, 1'b1);
    run(32'h00208863, 1'b0, lat, nrf, ndm, nbr, nil, rfph);
    chk("beq0_lat", lat, 2); chk("beq0_br", nbr, 0);

    // illegal word
    cnt_before = cu_retired_count;
    run(32'hFFFFFFFF, 1'b0, lat, nrf, ndm, nbr, nil, rfph);
    chk("ill_lat", lat, 1); chk("ill_n", nil, 1); chk("ill_strobes", nrf + ndm, 0);
    chk("ill_count", cu_retired_count, cnt_before);

    // sub / and / or / addi / add into x0
    run(32'h402081B3, 1'b0, lat, nrf, ndm, nbr, nil, rfph);
    chk("sub_alu", cu_alu_operation, 3'b001); chk("sub_rf_n", nrf, 1);
    run(32'h0020F1B3, 1'b0, lat, nrf, ndm, nbr, nil, rfph);
    chk("and_alu", cu_alu_operation, 3'b010);
    run(32'h0020E1B3, 1'b0, lat, nrf, ndm, nbr, nil, rfph);
    chk("or_alu", cu_alu_operation, 3'b011);
    run(32'hFFF08293, 1'b0, lat, nrf, ndm, nbr, nil, rfph);
    chk("addi_imm", cu_immediate, 64'hFFFF_FFFF_FFFF_FFFF); chk("addi_lat", lat, 3);
    chk("addi_mux", {cu_mux_1_sel, cu_mux_2_sel}, 2'b01); chk("addi_wa", cu_rf_write_addr, 5'd5);
    run(32'h00208033, 1'b0, lat, nrf, ndm, nbr, nil, rfph);
    chk("x0_lat", lat, 3); chk("x0_rf_n", nrf, 0);

    // valid held while busy: the second word must not be consumed
    @(posedge cu_clk); #1;
    cu_instr = 32'h002081B3; cu_instr_valid = 1'b1;
    @(posedge cu_clk); #1;
    cu_instr = 32'hFFFFFFFF;
    @(posedge cu_clk); #1;
    @(posedge cu_clk); #1;
    cu_instr_valid = 1'b0;
    @(posedge cu_clk); #1;
    chk("hold_busy", cu_busy, 1'b0); chk("hold_wa", cu_rf_write_addr, 5'd3);

    // reset during MEMORY of SD
    @(posedge cu_clk); #1;
    cu_instr = 32'hFE533C23; cu_instr_valid = 1'b1;
    @(posedge cu_clk); #1;
    cu_instr_valid = 1'b0;
    @(posedge cu_clk); #1;
    @(posedge cu_clk); #1;
    cu_rst = 1'b1;
    @(negedge cu_clk);
    chk("rstmem_dm", cu_dm_write_en, 1'b0); chk("rstmem_busy", cu_busy, 1'b1);
    @(posedge cu_clk); #1;
    cu_rst = 1'b0;
    @(negedge cu_clk);
    chk("rstmem_ready", cu_instr_ready, 1'b1); chk("rstmem_imm", cu_immediate, 64'd0);
    chk("rstmem_b", cu_rf_addr_b, 5'd0); chk("rstmem_count", cu_retired_count, 32'd0);

    // reset wins over a simultaneous handshake
    @(posedge cu_clk); #1;
    cu_rst = 1'b1; cu_instr = 32'h002081B3; cu_instr_valid = 1'b1;
    @(posedge cu_clk); #1;
    cu_rst = 1'b0; cu_instr_valid = 1'b0;
    @(negedge cu_clk);
    chk("rstvld_busy", cu_busy, 1'b0); chk("rstvld_wa", cu_rf_write_addr, 5'd0);

    @(posedge cu_clk); #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports in order below.
REQ-002 cu_clk  in  1  clock; all state updates on rising edge.
REQ-003 cu_rst  in  1  synchronous active-high reset.
REQ-004 cu_instr / cu_instr_valid / cu_instr_ready  in/in/out  32/1/1  instruction word and valid/ready handshake.
REQ-005 cu_alu_zero  in  1  datapath ALU zero flag, used by BEQ.
REQ-006 cu_rf_addr_a / cu_rf_addr_b / cu_rf_write_addr  out  5 each  rs1 / rs2 / rd.
REQ-007 cu_rf_write_en / cu_dm_write_en  out  1 each  register-file / data-memory write strobes.
REQ-008 cu_immediate  out  64  sign-extended immediate.
REQ-009 cu_mux_0_sel (0=rf_a, 1=PC), cu_mux_1_sel (0=immediate, 1=rf_b), cu_mux_2_sel (0=dm data, 1=alu result)  out  1 each.
REQ-010 cu_alu_operation  out  3  000 add, 001 sub, 010 and, 011 or.
REQ-011 cu_branch_taken / cu_illegal  out  1 each  one-cycle pulses; cu_busy  out  1  high when state != IDLE.
REQ-012 cu_retired_count  out  32  retired-instruction count (see Configuration).

Function
REQ-013 FSM states: IDLE, DECODE, EXECUTE, MEMORY, WRITEBACK.
REQ-014 cu_instr_ready high only in IDLE; valid&&ready latches cu_instr, next state DECODE.
REQ-015 DECODE: drive rf addresses, immediate, mux selects and alu op from the latched word.
REQ-016 Supported: LD (0000011/f3 011), SD (0100011/f3 011), ADDI (0010011/f3 000), ADD/SUB/AND/OR (0110011, f7 0000000/0100000), BEQ (1100011/f3 000).
REQ-017 Anything else: cu_illegal pulses in DECODE, next state IDLE, no write strobe.
REQ-018 Immediate: I-type inst[31:20], S-type {inst[31:25],inst[11:7]}, B-type {inst[31],inst[7],inst[30:25],inst[11:8],0}; sign-extended to 64; R-type drives 0.
REQ-019 Transitions: DECODE->EXECUTE; EXECUTE->MEMORY (LD/SD), ->WRITEBACK (R/ADDI), ->IDLE (BEQ); MEMORY->WRITEBACK (LD), ->IDLE (SD); WRITEBACK->IDLE.
REQ-020 Strobe cycles: cu_dm_write_en exactly one cycle in MEMORY for SD; cu_rf_write_en exactly one cycle in WRITEBACK; both 0 in every other cycle.
REQ-021 rd == x0: cu_rf_write_en suppressed; WRITEBACK still entered.
REQ-022 BEQ: alu op sub, mux_1_sel=1; cu_branch_taken = cu_alu_zero sampled in EXECUTE, pulsed in that cycle.
REQ-023 Latency from accept edge to return to IDLE: BEQ 2 cycles, SD 3, R/ADDI 3, LD 4, illegal 1.
REQ-024 Non-strobe outputs hold their last decoded values until the next DECODE.
REQ-025 cu_instr_valid while busy is ignored; the word is not consumed.

Reset
REQ-026 cu_rst forces IDLE on the next edge from any state; the latched instruction is discarded.
REQ-027 After reset, every output is 0 except cu_instr_ready, which is 1; cu_retired_count is 0.
REQ-028 Reset asserted during MEMORY or WRITEBACK: no strobe in that cycle.
REQ-029 Reset has priority over a simultaneous handshake.

Configuration
REQ-030 Macro CU_PERF_COUNT_EN defined: cu_retired_count increments by 1 on leaving WRITEBACK, MEMORY (SD) or EXECUTE (BEQ) to IDLE; illegal instructions are not counted; wraps 0xFFFFFFFF->0.
REQ-031 Macro CU_PERF_COUNT_EN undefined: cu_retired_count is constant 0 and no counter register exists.

Verification
REQ-032 cu_instr=0x0053B103 (ld x2,5(x7)) -> addr_a=7, write_addr=2, imm=0x5, mux0/1/2=0/0/0, alu=000; rf_write_en single pulse 4 cycles after accept.
REQ-033 0x002081B3 (add x3,x1,x2) -> addr_a=1, addr_b=2, mux1=1, mux2=1, alu=000; rf_write_en pulse 3 cycles after accept; dm_write_en never high.
REQ-034 0xFE533C23 (sd x5,-8(x6)) -> imm=0xFFFFFFFFFFFFFFF8, addr_b=5; dm_write_en single pulse in MEMORY; rf_write_en never high.
REQ-035 0x00208863 (beq x1,x2,+16) with alu_zero=1 -> imm=0x10, alu=001, branch_taken pulse; with alu_zero=0 -> no pulse; ready returns after 2 cycles.
REQ-036 0xFFFFFFFF -> cu_illegal pulse, no strobes, ready next cycle; retired count unchanged.
REQ-037 Reset asserted in MEMORY of SD -> no dm_write_en; IDLE next cycle; outputs 0 except ready=1.
